// File: rtl/image_pixel_proc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | img_pkg : shared mode/state encodings and saturation helper          |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package img_pkg;

  localparam logic [2:0] MODE_BYPASS   = 3'd0;
  localparam logic [2:0] MODE_ADD      = 3'd1;
  localparam logic [2:0] MODE_SUB      = 3'd2;
  localparam logic [2:0] MODE_INVERT   = 3'd3;
  localparam logic [2:0] MODE_THRESH   = 3'd4;
  localparam logic [2:0] MODE_CONTRAST = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Clamp a signed intermediate into the unsigned range of a dw-bit channel.
  function automatic int sat_u(input int value, input int dw);
    int max_v;
    max_v = (1 << dw) - 1;
    if (value < 0) return 0;
    else if (value > max_v) return max_v;
    else return value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/image_pixel_proc_lane_op.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | img_lane_op : combinational point operation on one RGB pixel         |
// | Mode 5 contrast only when IMG_CONTRAST_EN is defined.  Rev 1.0       |
// +----------------------------------------------------------------------+
module img_lane_op
  import img_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [2:0]      mode_i,
  input  logic [DW-1:0]   value_i,
  input  logic [DW-1:0]   thresh_i,
  input  logic [3*DW-1:0] pix_i,
  input  logic [DW+1:0]   sum_i,
  output logic [3*DW-1:0] pix_o
);

  localparam int SW = DW + 2;
  localparam logic [SW-1:0] c_THREE = SW'(3);
  localparam logic [DW-1:0] c_MAXV  = '1;

  logic [SW-1:0] gray;
  logic [DW-1:0] inv;

  assign gray = sum_i / c_THREE;
  assign inv  = c_MAXV - gray[DW-1:0];

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [DW-1:0] x;
    logic [DW-1:0] y;

    assign x = pix_i[DW*c +: DW];

`ifdef IMG_CONTRAST_EN
    localparam logic signed [2*DW+1:0] c_HALF_S =
      {{(DW+2){1'b0}}, 1'b1, {(DW-1){1'b0}}};
    logic signed [2*DW+1:0] prod;
    logic signed [2*DW+1:0] con;
    // Gain is 4.4 fixed point, so the >>>4 removes the fractional bits.
    assign prod = ($signed({{(DW+2){1'b0}}, x}) - c_HALF_S) *
                  $signed({{(DW+2){1'b0}}, value_i});
    assign con  = (prod >>> 4) + c_HALF_S;
`endif

    always_comb begin
      y = x;
      case (mode_i)
        MODE_ADD:      y = DW'(sat_u(int'(x) + int'(value_i), DW));
        MODE_SUB:      y = (x > value_i) ? (x - value_i) : '0;
        MODE_INVERT:   y = inv;
        MODE_THRESH:   y = (gray > {2'b00, thresh_i}) ? c_MAXV : '0;
`ifdef IMG_CONTRAST_EN
        MODE_CONTRAST: y = DW'(sat_u(int'(con), DW));
`endif
        default:       y = x;
      endcase
    end

    assign pix_o[DW*c +: DW] = y;
  end

endmodule
`default_nettype wire

// File: rtl/image_pixel_proc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | image_pixel_proc : 2-stage streaming RGB point-operation engine      |
// | Optional contrast mode via IMG_CONTRAST_EN.  Rev 1.0                 |
// +----------------------------------------------------------------------+
module image_pixel_proc
  import img_pkg::*;
#(
  parameter  int WIDTH  = 768,
  parameter  int HEIGHT = 512,
  parameter  int DW     = 8,
  parameter  int LANES  = 1,
  localparam int PW     = 3 * DW * LANES
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          start,
  input  logic [2:0]    cfg_mode,
  input  logic [DW-1:0] cfg_value,
  input  logic [DW-1:0] cfg_threshold,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [PW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [PW-1:0] m_data,
  output logic          m_sof,
  output logic          m_eol,
  output logic          m_eof,
  output logic          HSYNC,
  output logic          busy,
  output logic          frame_done
);

  localparam int TOTAL = WIDTH * HEIGHT / LANES;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int COLW  = $clog2(WIDTH + 1);
  localparam int ROWW  = $clog2(HEIGHT + 1);
  localparam int SW    = DW + 2;

  localparam logic [CW-1:0]   c_TOTAL    = CW'(TOTAL);
  localparam logic [COLW-1:0] c_COL_LAST = COLW'(WIDTH - LANES);
  localparam logic [COLW-1:0] c_COL_STEP = COLW'(LANES);
  localparam logic [ROWW-1:0] c_ROW_LAST = ROWW'(HEIGHT - 1);

  state_t                 state_q, state_d;
  logic [CW-1:0]          in_cnt_q, in_cnt_d;
  logic [COLW-1:0]        col_q, col_d;
  logic [ROWW-1:0]        row_q, row_d;
  logic [2:0]             mode_q;
  logic [DW-1:0]          value_q, thresh_q;
  logic                   st1_valid_q, st2_valid_q;
  logic [PW-1:0]          st1_data_q, st2_data_q;
  logic [LANES*SW-1:0]    st1_sum_q;

  logic                   adv, s_fire, cfg_load, last_col;
  logic [LANES*SW-1:0]    sum;
  logic [PW-1:0]          res;

  // One enable for both stages keeps the pipeline lossless under back-pressure.
  assign adv     = !st2_valid_q || m_ready;
  assign s_ready = (state_q == ST_RUN) && (in_cnt_q < c_TOTAL) && adv;
  assign s_fire  = s_valid && s_ready;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DW-1:0] r, g, b;
    assign r = s_data[3*DW*k + 2*DW +: DW];
    assign g = s_data[3*DW*k + DW   +: DW];
    assign b = s_data[3*DW*k        +: DW];
    assign sum[SW*k +: SW] = {2'b00, r} + {2'b00, g} + {2'b00, b};

    img_lane_op #(.DW(DW)) u_op (
      .mode_i   (mode_q),
      .value_i  (value_q),
      .thresh_i (thresh_q),
      .pix_i    (st1_data_q[3*DW*k +: 3*DW]),
      .sum_i    (st1_sum_q[SW*k +: SW]),
      .pix_o    (res[3*DW*k +: 3*DW])
    );
  end

  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    cfg_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          in_cnt_d = '0;
          cfg_load = 1'b1;
        end
      end
      ST_RUN: begin
        if (s_fire) in_cnt_d = in_cnt_q + 1'b1;
        if (in_cnt_q == c_TOTAL) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (HSYNC && m_eof) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (HSYNC) begin
      if (last_col) begin
        col_d = '0;
        row_d = (row_q == c_ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + c_COL_STEP;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      in_cnt_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= '0;
      value_q     <= '0;
      thresh_q    <= '0;
      st1_valid_q <= 1'b0;
      st1_data_q  <= '0;
      st1_sum_q   <= '0;
      st2_valid_q <= 1'b0;
      st2_data_q  <= '0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      col_q    <= col_d;
      row_q    <= row_d;
      if (cfg_load) begin
        mode_q   <= cfg_mode;
        value_q  <= cfg_value;
        thresh_q <= cfg_threshold;
      end
      if (adv) begin
        st1_valid_q <= s_fire;
        st1_data_q  <= s_data;
        st1_sum_q   <= sum;
        st2_valid_q <= st1_valid_q;
        st2_data_q  <= res;
      end
    end
  end

  // Markers come from the output counters, which only move on a handshake.
  assign last_col   = (col_q == c_COL_LAST);
  assign m_valid    = st2_valid_q;
  assign m_data     = st2_data_q;
  assign m_sof      = st2_valid_q && (row_q == '0) && (col_q == '0);
  assign m_eol      = st2_valid_q && last_col;
  assign m_eof      = m_eol && (row_q == c_ROW_LAST);
  assign HSYNC      = m_valid && m_ready;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_image_pixel_proc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_image_pixel_proc : directed self-checking bench, 4x2 frames,      |
// | LANES=1 instance (ops/markers/reset) and LANES=2 instance (stall)    |
// +----------------------------------------------------------------------+
module tb_image_pixel_proc;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;

  always #5 HCLK = ~HCLK;

  // instance a: LANES = 1
  logic        a_start = 0, a_s_valid = 0, a_m_ready = 0;
  logic [2:0]  a_cfg_mode = 0;
  logic [7:0]  a_cfg_value = 0, a_cfg_threshold = 0;
  logic [23:0] a_s_data = 0;
  logic        a_s_ready, a_m_valid, a_m_sof, a_m_eol, a_m_eof;
  logic        a_HSYNC, a_busy, a_frame_done;
  logic [23:0] a_m_data;

  // instance b: LANES = 2
  logic        b_start = 0, b_s_valid = 0, b_m_ready = 0;
  logic [2:0]  b_cfg_mode = 0;
  logic [7:0]  b_cfg_value = 0, b_cfg_threshold = 0;
  logic [47:0] b_s_data = 0;
  logic        b_s_ready, b_m_valid, b_m_sof, b_m_eol, b_m_eof;
  logic        b_HSYNC, b_busy, b_frame_done;
  logic [47:0] b_m_data;

  int n_cmp = 0;
  int n_err = 0;

  image_pixel_proc #(.WIDTH(4), .HEIGHT(2), .DW(8), .LANES(1)) u_dut_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(a_start),
    .cfg_mode(a_cfg_mode), .cfg_value(a_cfg_value), .cfg_threshold(a_cfg_threshold),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
    .m_sof(a_m_sof), .m_eol(a_m_eol), .m_eof(a_m_eof),
    .HSYNC(a_HSYNC), .busy(a_busy), .frame_done(a_frame_done)
  );

  image_pixel_proc #(.WIDTH(4), .HEIGHT(2), .DW(8), .LANES(2)) u_dut_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(b_start),
    .cfg_mode(b_cfg_mode), .cfg_value(b_cfg_value), .cfg_threshold(b_cfg_threshold),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
    .m_sof(b_m_sof), .m_eol(b_m_eol), .m_eof(b_m_eof),
    .HSYNC(b_HSYNC), .busy(b_busy), .frame_done(b_frame_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Beat j of the LANES=2 stream: lane1 in the upper 24 bits.
  function automatic logic [47:0] mk_beat(input int j);
    logic [7:0] base;
    base = 8'(16 * j);
    return {base + 8'd5, base + 8'd6, base + 8'd7, base + 8'd1, base + 8'd2, base + 8'd3};
  endfunction

  // Run one full 4x2 frame on instance a with a constant pixel.
  task automatic run_a(input string tag, input logic [2:0] mode, input logic [7:0] val,
                       input logic [7:0] thr, input logic [23:0] pix, input logic [23:0] exp_pix);
    int in_i, out_i, cyc;
    bit done_seen, last_hs;
    @(negedge HCLK);
    a_cfg_mode = mode; a_cfg_value = val; a_cfg_threshold = thr; a_start = 1'b1;
    @(negedge HCLK);
    a_start = 1'b0;
    a_cfg_mode = 3'd7; a_cfg_value = 8'hA5; a_cfg_threshold = 8'h00;
    #1;
    check({tag, "_busy_run"}, a_busy, 1);
    in_i = 0; out_i = 0; cyc = 0; done_seen = 0; last_hs = 0;
    while (!done_seen && cyc < 60) begin
      a_s_valid = (in_i < 8); a_s_data = pix; a_m_ready = 1'b1;
      #1;
      if (a_frame_done) begin
        check({tag, "_fdone_after_eof"}, last_hs, 1);
        done_seen = 1;
      end
      last_hs = 0;
      if (a_m_valid && a_m_ready) begin
        check({tag, "_data"}, a_m_data, exp_pix);
        check({tag, "_sof"}, a_m_sof, out_i == 0);
        check({tag, "_eol"}, a_m_eol, (out_i % 4) == 3);
        check({tag, "_eof"}, a_m_eof, out_i == 7);
        last_hs = (out_i == 7);
        out_i++;
      end
      if (a_s_valid && a_s_ready) in_i++;
      @(negedge HCLK);
      cyc++;
    end
    a_s_valid = 1'b0;
    #1;
    check({tag, "_accepted"}, in_i, 8);
    check({tag, "_beats"}, out_i, 8);
    check({tag, "_frame_done_seen"}, done_seen, 1);
    check({tag, "_busy_idle"}, a_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int in_i, out_i, cyc, first_in, first_out;
    bit done_seen;

    repeat (3) @(negedge HCLK);
    #1;
    check("rst_m_valid", a_m_valid, 0);
    check("rst_m_data", a_m_data, 0);
    check("rst_busy", a_busy, 0);
    check("rst_s_ready", a_s_ready, 0);
    check("rst_frame_done", a_frame_done, 0);
    check("rst_sof", a_m_sof, 0);
    HRESETn = 1'b1;

    run_a("add",     3'd1, 8'd100, 8'd0,  {8'd200, 8'd50,  8'd255}, {8'd255, 8'd150, 8'd255});
    run_a("sub",     3'd2, 8'd100, 8'd0,  {8'd90,  8'd100, 8'd101}, {8'd0,   8'd0,   8'd1});
    run_a("thr_eq",  3'd4, 8'd0,   8'd90, {8'd90,  8'd90,  8'd90},  24'h000000);
    run_a("thr_gt",  3'd4, 8'd0,   8'd90, {8'd91,  8'd91,  8'd92},  24'hFFFFFF);
    run_a("inv",     3'd3, 8'd0,   8'd0,  {8'd30,  8'd60,  8'd90},  {8'd195, 8'd195, 8'd195});
    run_a("mode6",   3'd6, 8'd77,  8'd0,  {8'd12,  8'd34,  8'd56},  {8'd12,  8'd34,  8'd56});
`ifdef IMG_CONTRAST_EN
    run_a("contrast", 3'd5, 8'h20, 8'd0,  {8'd64,  8'd128, 8'd200}, {8'd0,   8'd128, 8'd255});
`else
    run_a("contrast", 3'd5, 8'h20, 8'd0,  {8'd64,  8'd128, 8'd200}, {8'd64,  8'd128, 8'd200});
`endif

    // LANES=2 frame with a 5-cycle output stall, mode 1, v=1
    @(negedge HCLK);
    b_cfg_mode = 3'd1; b_cfg_value = 8'd1; b_start = 1'b1;
    @(negedge HCLK);
    b_start = 1'b0; b_cfg_value = 8'd99;
    in_i = 0; out_i = 0; cyc = 0; first_in = -1; first_out = -1;
    while (out_i < 4 && cyc < 60) begin
      b_m_ready = !(cyc >= 3 && cyc < 8);
      b_s_valid = (in_i < 4);
      b_s_data  = mk_beat(in_i);
      #1;
      if (b_m_valid && first_out < 0) first_out = cyc;
      if (b_m_valid && !b_m_ready) begin
        check("stall_s_ready", b_s_ready, 0);
        check("stall_hsync", b_HSYNC, 0);
        check("stall_hold_data", b_m_data, mk_beat(out_i) + 48'h010101010101);
        check("stall_hold_eol", b_m_eol, (out_i % 2) == 1);
      end
      if (b_m_valid && b_m_ready) begin
        check("l2_data", b_m_data, mk_beat(out_i) + 48'h010101010101);
        check("l2_sof", b_m_sof, out_i == 0);
        check("l2_eol", b_m_eol, (out_i % 2) == 1);
        check("l2_eof", b_m_eof, out_i == 3);
        check("l2_hsync", b_HSYNC, 1);
        out_i++;
      end
      if (b_s_valid && b_s_ready) begin
        if (first_in < 0) first_in = cyc;
        in_i++;
      end
      @(negedge HCLK);
      cyc++;
    end
    b_s_valid = 1'b0;
    check("l2_beats", out_i, 4);
    check("l2_latency", first_out - first_in, 2);
    done_seen = 0;
    for (int i = 0; i < 10 && !done_seen; i++) begin
      #1;
      if (b_frame_done) done_seen = 1;
      @(negedge HCLK);
    end
    #1;
    check("l2_frame_done", done_seen, 1);
    check("l2_busy_idle", b_busy, 0);

    // Reset in the middle of a frame, after 3 accepted beats
    @(negedge HCLK);
    a_cfg_mode = 3'd0; a_start = 1'b1;
    @(negedge HCLK);
    a_start = 1'b0;
    in_i = 0; cyc = 0;
    while (in_i < 3 && cyc < 20) begin
      a_s_valid = 1'b1; a_s_data = 24'h112233; a_m_ready = 1'b1;
      #1;
      if (a_s_valid && a_s_ready) in_i++;
      @(negedge HCLK);
      cyc++;
    end
    a_s_valid = 1'b0;
    check("mid_accepted", in_i, 3);
    HRESETn = 1'b0;
    #1;
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_m_valid", a_m_valid, 0);
    check("mid_rst_m_data", a_m_data, 0);
    check("mid_rst_hsync", a_HSYNC, 0);
    repeat (2) @(negedge HCLK);
    #1;
    check("mid_rst_hold_busy", a_busy, 0);
    HRESETn = 1'b1;
    run_a("after_rst", 3'd0, 8'd0, 8'd0, {8'd1, 8'd2, 8'd3}, {8'd1, 8'd2, 8'd3});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
